// File: rtl/icb_multibank_slave.sv
// ICB slave front-end for the accelerator: control/status registers plus a bank-selected
// SRAM data window, with a start/busy/done handshake to the compute core and a level IRQ.
module icb_multibank_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h1004_2000,
  parameter int          NUM_BANKS = 4,
  parameter int          BANK_AW   = 10,
  parameter int          RD_LAT    = 1,
  parameter int          MODE_W    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    icb_cmd_valid,
  output logic                    icb_cmd_ready,
  input  logic                    icb_cmd_read,
  input  logic [31:0]             icb_cmd_addr,
  input  logic [31:0]             icb_cmd_wdata,
  input  logic [3:0]              icb_cmd_wmask,
  output logic                    icb_rsp_valid,
  input  logic                    icb_rsp_ready,
  output logic [31:0]             icb_rsp_rdata,
  output logic                    icb_rsp_err,
  output logic [NUM_BANKS-1:0]    mem_cs,
  output logic                    mem_we,
  output logic [BANK_AW-1:0]      mem_addr,
  output logic [31:0]             mem_wdata,
  output logic [3:0]              mem_wmask,
  input  logic [NUM_BANKS*32-1:0] mem_rdata,
  output logic                    acc_start,
  output logic [MODE_W-1:0]       acc_mode,
  input  logic                    acc_done,
  output logic                    irq
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_RSP     = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_irq_en;
  logic [3:0]          r_bank_sel;
  logic [MODE_W-1:0]   r_mode;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_irq;
  logic                r_acc_start;

  logic [31:0]         r_rsp_rdata;
  logic                r_rsp_err;
  logic [3:0]          r_rd_bank;
  logic [1:0]          r_lat_cnt;

  logic [15:0]         w_off;
  logic [11:0]         w_word;
  logic                w_base_ok;
  logic                w_aligned;
  logic                w_is_ctrl;
  logic                w_is_bank;
  logic                w_is_stat;
  logic                w_is_mode;
  logic                w_is_win;
  logic                w_wr_b0;
  logic                w_start_req;
  logic                w_bank_bad;
  logic                w_err;
  logic                w_accept;
  logic                w_ok;
  logic                w_win_acc;
  logic                w_reg_wr;
  logic                w_start;
  logic [31:0]         w_reg_rdata;
  logic [31:0]         w_bank_rdata;

  // ---------------------------------------------------------------- decode
  assign w_off     = icb_cmd_addr[15:0];
  assign w_word    = w_off[13:2];
  assign w_base_ok = (icb_cmd_addr[31:16] == BASE_ADDR[31:16]);
  assign w_aligned = (icb_cmd_addr[1:0] == 2'b00);
  assign w_is_ctrl = (w_off == 16'h0000);
  assign w_is_bank = (w_off == 16'h0004);
  assign w_is_stat = (w_off == 16'h0008);
  assign w_is_mode = (w_off == 16'h000C);
  assign w_is_win  = (w_off[15:14] == 2'b01) && ({20'd0, w_word} < (32'd1 << BANK_AW));

  // Every register field lives in byte 0, so byte-0 mask gates all register side effects.
  assign w_wr_b0     = ~icb_cmd_read & icb_cmd_wmask[0];
  assign w_start_req = w_is_ctrl & w_wr_b0 & icb_cmd_wdata[0];
  assign w_bank_bad  = w_is_bank & w_wr_b0 & ({24'd0, icb_cmd_wdata[7:0]} >= 32'(NUM_BANKS));

  assign w_err = ~w_base_ok | ~w_aligned
               | ~(w_is_ctrl | w_is_bank | w_is_stat | w_is_mode | w_is_win)
               | w_bank_bad
               | (w_start_req & r_busy)
               | (w_is_win & ~icb_cmd_read & r_busy);

  // rst_n also gates ready so that every output, including this combinational one, is 0 in reset.
  assign icb_cmd_ready = (r_state == S_IDLE) & rst_n;
  assign w_accept      = icb_cmd_valid & icb_cmd_ready;
  assign w_ok          = w_accept & ~w_err;
  assign w_win_acc     = w_ok & w_is_win;
  assign w_reg_wr      = w_ok & ~w_is_win & w_wr_b0;
  assign w_start       = w_reg_wr & w_is_ctrl & icb_cmd_wdata[0];

  // ---------------------------------------------------------------- SRAM port (cycle A only)
  // NOTE: every signal driven from an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    mem_cs = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      mem_cs[b] = w_win_acc & (r_bank_sel == 4'(b));
    end
  end

  assign mem_we    = w_win_acc & ~icb_cmd_read;
  assign mem_addr  = w_win_acc ? w_word[BANK_AW-1:0] : '0;
  assign mem_wdata = mem_we ? icb_cmd_wdata : '0;
  assign mem_wmask = mem_we ? icb_cmd_wmask : '0;

  always_comb begin
    w_bank_rdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (r_rd_bank == 4'(b)) w_bank_rdata = mem_rdata[32*b +: 32];
    end
  end

  always_comb begin
    w_reg_rdata = '0;
    if (w_is_ctrl)      w_reg_rdata[1]          = r_irq_en;
    else if (w_is_bank) w_reg_rdata[3:0]        = r_bank_sel;
    else if (w_is_stat) w_reg_rdata[2:0]        = {r_err, r_done, r_busy};
    else if (w_is_mode) w_reg_rdata[MODE_W-1:0] = r_mode;
  end

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = (w_win_acc & icb_cmd_read) ? S_RD_WAIT : S_RSP;
      end
      S_RD_WAIT: begin
        if (r_lat_cnt == 2'd0) w_state_nxt = S_RSP;
      end
      S_RSP: begin
        if (icb_rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- response path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rd_bank   <= '0;
      r_lat_cnt   <= '0;
    end else if (w_accept) begin
      r_rsp_err   <= w_err;
      r_rsp_rdata <= (icb_cmd_read & ~w_err & ~w_is_win) ? w_reg_rdata : '0;
      r_rd_bank   <= r_bank_sel;
      r_lat_cnt   <= 2'(RD_LAT - 1);
    end else if (r_state == S_RD_WAIT) begin
      // Bank data is valid in the last wait cycle; capture it on that edge.
      if (r_lat_cnt == 2'd0) r_rsp_rdata <= w_bank_rdata;
      else                   r_lat_cnt   <= r_lat_cnt - 2'd1;
    end
  end

  assign icb_rsp_valid = (r_state == S_RSP);
  assign icb_rsp_rdata = r_rsp_rdata;
  assign icb_rsp_err   = r_rsp_err;

  // ---------------------------------------------------------------- control/status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_en    <= 1'b0;
      r_bank_sel  <= '0;
      r_mode      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_irq       <= 1'b0;
      r_acc_start <= 1'b0;
    end else begin
      if (w_reg_wr & w_is_ctrl) r_irq_en   <= icb_cmd_wdata[1];
      if (w_reg_wr & w_is_bank) r_bank_sel <= icb_cmd_wdata[3:0];
      if (w_reg_wr & w_is_mode) r_mode     <= icb_cmd_wdata[MODE_W-1:0];
      r_acc_start <= w_start;

      if (w_start)       r_busy <= 1'b1;
      else if (acc_done) r_busy <= 1'b0;

      // Set sources take priority over write-1-to-clear.
      if (acc_done)                                       r_done <= 1'b1;
      else if (w_reg_wr & w_is_stat & icb_cmd_wdata[1])   r_done <= 1'b0;

      if (w_accept & w_err)                               r_err  <= 1'b1;
      else if (w_reg_wr & w_is_stat & icb_cmd_wdata[2])   r_err  <= 1'b0;

      r_irq <= r_irq_en & r_done;
    end
  end

  assign acc_start = r_acc_start;
  assign acc_mode  = r_mode;
  assign irq       = r_irq;

endmodule

// File: tb/tb_icb_multibank_slave.sv
// Randomised scoreboard bench for icb_multibank_slave: a behavioural register/memory model
// predicts each response; a monitor checks latency, hold stability and data against it.
module tb_icb_multibank_slave;

  localparam int NB = 4;
  localparam int AW = 10;
  localparam int RL = 2;
  localparam int MW = 3;
  localparam logic [31:0] BASE = 32'h1004_0000;
  localparam logic [31:0] WIN  = 32'h1004_4000;

  typedef struct {
    logic [31:0]   rdata;
    logic          err;
    logic [NB-1:0] cs;
    logic          we;
    logic          start;
    int            word;
    int            lat;
    int            acc_cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              icb_cmd_valid = 1'b0;
  logic              icb_cmd_ready;
  logic              icb_cmd_read = 1'b0;
  logic [31:0]       icb_cmd_addr = '0;
  logic [31:0]       icb_cmd_wdata = '0;
  logic [3:0]        icb_cmd_wmask = '0;
  logic              icb_rsp_valid;
  logic              icb_rsp_ready = 1'b1;
  logic [31:0]       icb_rsp_rdata;
  logic              icb_rsp_err;
  logic [NB-1:0]     mem_cs;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wmask;
  logic [NB*32-1:0]  mem_rdata;
  logic              acc_start;
  logic [MW-1:0]     acc_mode;
  logic              acc_done = 1'b0;
  logic              irq;

  icb_multibank_slave #(
    .BASE_ADDR(32'h1004_2000), .NUM_BANKS(NB), .BANK_AW(AW), .RD_LAT(RL), .MODE_W(MW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_rdata(icb_rsp_rdata),
    .icb_rsp_err(icb_rsp_err),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .acc_start(acc_start), .acc_mode(acc_mode), .acc_done(acc_done), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- SRAM environment
  logic [31:0] sram [NB][1 << AW];
  logic [31:0] pipe [NB][RL];
  bit          sram_ready = 1'b0;

  always @(posedge clk) begin
    if (!sram_ready) begin
      for (int b = 0; b < NB; b++)
        for (int w = 0; w < (1 << AW); w++) sram[b][w] <= '0;
      sram_ready <= 1'b1;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (mem_cs[b] && mem_we)
          for (int k = 0; k < 4; k++)
            if (mem_wmask[k]) sram[b][mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
    end
    for (int b = 0; b < NB; b++) begin
      // Junk when not selected so a mistimed capture cannot pass by accident.
      pipe[b][0] <= (mem_cs[b] && !mem_we) ? sram[b][mem_addr] : (32'hBAD0_0000 | 32'(b));
      for (int k = 1; k < RL; k++) pipe[b][k] <= pipe[b][k-1];
    end
  end

  always_comb begin
    mem_rdata = '0;
    for (int b = 0; b < NB; b++) mem_rdata[32*b +: 32] = pipe[b][RL-1];
  end

  // ---------------------------------------------------------------- reference model
  logic [31:0] ref_mem [NB][1 << AW];
  bit          m_irq_en, m_busy, m_done, m_err;
  int          m_bank;
  logic [MW-1:0] m_mode;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];
  int stall_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic model_reset();
    m_irq_en = 0; m_busy = 0; m_done = 0; m_err = 0; m_bank = 0; m_mode = '0;
  endtask

  task automatic model_txn(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wmask, output exp_t e);
    int  off;
    bit  is_win, wb0;
    off    = int'(addr[15:0]);
    is_win = (off >= 'h4000) && (off < 'h4000 + 4 * (1 << AW));
    wb0    = !rd && wmask[0];
    e = '{rdata: '0, err: 1'b0, cs: '0, we: 1'b0, start: 1'b0, word: 0, lat: 1, acc_cyc: 0};
    if (addr[31:16] != 16'h1004 || addr[1:0] != 2'b00) begin
      e.err = 1'b1;
    end else if (is_win) begin
      if (!rd && m_busy) e.err = 1'b1;
      else begin
        e.word = (off - 'h4000) / 4;
        e.cs[m_bank] = 1'b1;
        e.we = !rd;
        if (rd) begin
          e.rdata = ref_mem[m_bank][e.word];
          e.lat   = RL + 1;
        end else begin
          for (int k = 0; k < 4; k++)
            if (wmask[k]) ref_mem[m_bank][e.word][8*k +: 8] = wdata[8*k +: 8];
        end
      end
    end else begin
      case (off)
        'h0: if (rd) e.rdata = {30'd0, m_irq_en, 1'b0};
             else if (wb0) begin
               if (wdata[0] && m_busy) e.err = 1'b1;
               else begin
                 m_irq_en = wdata[1];
                 if (wdata[0]) begin e.start = 1'b1; m_busy = 1; end
               end
             end
        'h4: if (rd) e.rdata = 32'(m_bank);
             else if (wb0) begin
               if (int'(wdata[7:0]) >= NB) e.err = 1'b1;
               else m_bank = int'(wdata[7:0]);
             end
        'h8: if (rd) e.rdata = {29'd0, m_err, m_done, m_busy};
             else if (wb0) begin
               if (wdata[1]) m_done = 0;
               if (wdata[2]) m_err = 0;
             end
        'hC: if (rd) e.rdata = 32'(m_mode);
             else if (wb0) m_mode = wdata[MW-1:0];
        default: e.err = 1'b1;
      endcase
    end
    if (e.err) m_err = 1;
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!icb_cmd_ready && n < 300);
    if (!icb_cmd_ready) begin
      check("idle_timeout", 32'(icb_cmd_ready), 32'd1);
      finish_run();
    end
  endtask

  task automatic do_txn(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask, input bit done_in_acc = 0, input int stall = 0);
    exp_t e;
    bit   busy_pre, irq_exp;
    wait_idle();
    busy_pre = m_busy;
    irq_exp  = m_irq_en & m_done;
    model_txn(rd, addr, wdata, wmask, e);
    e.acc_cyc  = cyc;
    stall_left = stall;
    sb.push_back(e);
    icb_cmd_valid = 1'b1; icb_cmd_read = rd; icb_cmd_addr = addr;
    icb_cmd_wdata = wdata; icb_cmd_wmask = wmask; acc_done = done_in_acc;
    @(negedge clk);
    check("cmd_ready", 32'(icb_cmd_ready), 32'd1);
    check("mem_cs", 32'(mem_cs), 32'(e.cs));
    check("mem_we", 32'(mem_we), 32'(e.we));
    if (e.cs != '0) check("mem_addr", 32'(mem_addr), 32'(e.word));
    check("irq", 32'(irq), 32'(irq_exp));
    @(posedge clk); #1;
    icb_cmd_valid = 1'b0; acc_done = 1'b0;
    check("acc_start", 32'(acc_start), 32'(e.start));
    if (done_in_acc) begin
      m_done = 1;
      if (busy_pre) m_busy = 0;
    end
  endtask

  task automatic pulse_done();
    @(posedge clk); #1; acc_done = 1'b1;
    @(posedge clk); #1; acc_done = 1'b0;
    m_done = 1; m_busy = 0;
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, 32'(icb_cmd_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(icb_rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, icb_rsp_rdata, 32'd0);
    check({tag, "_rsp_err"},   32'(icb_rsp_err), 32'd0);
    check({tag, "_mem_cs"},    32'(mem_cs), 32'd0);
    check({tag, "_mem_we"},    32'(mem_we), 32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_mem_wmask"}, 32'(mem_wmask), 32'd0);
    check({tag, "_acc_start"}, 32'(acc_start), 32'd0);
    check({tag, "_acc_mode"},  32'(acc_mode), 32'd0);
    check({tag, "_irq"},       32'(irq), 32'd0);
  endtask

  // ---------------------------------------------------------------- response ready
  initial begin
    forever begin
      @(posedge clk); #1;
      if (icb_rsp_valid && stall_left > 0) begin
        icb_rsp_ready = 1'b0;
        stall_left--;
      end else begin
        icb_rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // ---------------------------------------------------------------- monitor
  initial begin
    bit          in_rsp = 0;
    logic [31:0] held_rdata = '0;
    logic        held_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_rsp = 0;
      end else if (icb_rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(icb_rsp_valid), 32'd0);
        end else begin
          if (!in_rsp) begin
            check("rsp_latency", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].lat));
            held_rdata = icb_rsp_rdata;
            held_err   = icb_rsp_err;
            in_rsp     = 1;
          end else begin
            check("rsp_hold_rdata", icb_rsp_rdata, held_rdata);
            check("rsp_hold_err", 32'(icb_rsp_err), 32'(held_err));
          end
          if (icb_rsp_ready) begin
            check("rsp_rdata", icb_rsp_rdata, sb[0].rdata);
            check("rsp_err", 32'(icb_rsp_err), 32'(sb[0].err));
            void'(sb.pop_front());
            in_rsp = 0;
          end
        end
      end
    end
  end

  initial begin
    #900000;
    check("watchdog", 32'd0, 32'd1);
    finish_run();
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [31:0] addr, wdata;
    logic [3:0]  wmask;
    logic        rd;
    int          sel;
    logic [31:0] unmapped [4];
    unmapped[0] = BASE | 32'h0010; unmapped[1] = BASE | 32'h3FFC;
    unmapped[2] = BASE | 32'h5000; unmapped[3] = BASE | 32'hFFFC;

    for (int b = 0; b < NB; b++)
      for (int w = 0; w < (1 << AW); w++) ref_mem[b][w] = '0;
    model_reset();

    #3;
    check_all_zero("por");
    #19 rst_n = 1'b1;

    // Bank select, full-word write and stalled read-back.
    do_txn(0, BASE | 32'h4, 32'd2, 4'hF);
    do_txn(0, WIN | 32'h8, 32'hDEAD_BEEF, 4'hF);
    do_txn(1, WIN | 32'h8, 32'h0, 4'h0, 0, 3);
    // Partial byte mask over an all-ones word.
    do_txn(0, WIN | 32'hC, 32'hFFFF_FFFF, 4'hF);
    do_txn(0, WIN | 32'hC, 32'h1122_3344, 4'b0011);
    do_txn(1, WIN | 32'hC, 32'h0, 4'h0);
    // Out-of-range bank select.
    do_txn(0, BASE | 32'h4, 32'd4, 4'hF);
    do_txn(1, BASE | 32'h4, 32'h0, 4'h0);
    do_txn(1, BASE | 32'h8, 32'h0, 4'h0);
    do_txn(0, BASE | 32'h8, 32'h4, 4'hF);
    // Mode, and a register write without byte 0 enabled.
    do_txn(0, BASE | 32'hC, 32'h5, 4'hF);
    do_txn(0, BASE | 32'hC, 32'h7, 4'hE);
    do_txn(1, BASE | 32'hC, 32'h0, 4'h0);
    // Start/busy/done/irq handshake.
    do_txn(0, BASE | 32'h0, 32'h3, 4'hF);
    do_txn(0, BASE | 32'h0, 32'h1, 4'hF);
    do_txn(0, BASE | 32'h8, 32'h4, 4'hF);
    do_txn(0, WIN | 32'h10, 32'h1234_5678, 4'hF);
    do_txn(1, WIN | 32'h8, 32'h0, 4'h0);
    do_txn(1, BASE | 32'h8, 32'h0, 4'h0);
    pulse_done();
    do_txn(1, BASE | 32'h8, 32'h0, 4'h0);
    do_txn(0, BASE | 32'h8, 32'h2, 4'hF);
    do_txn(1, BASE | 32'h8, 32'h0, 4'h0);
    // Decode errors: wrong base, misaligned, top of window, just past window.
    do_txn(1, 32'h1005_0000, 32'h0, 4'h0);
    do_txn(0, 32'h1004_2002, 32'hFFFF_FFFF, 4'hF);
    do_txn(0, WIN | 32'hFFC, 32'hA5A5_5A5A, 4'hF);
    do_txn(1, WIN | 32'hFFC, 32'h0, 4'h0);
    do_txn(1, BASE | 32'h5000, 32'h0, 4'h0);
    // Done set beats a simultaneous write-1-to-clear.
    do_txn(0, BASE | 32'h8, 32'h6, 4'hF, 1);
    do_txn(1, BASE | 32'h8, 32'h0, 4'h0);

    for (int i = 0; i < 250; i++) begin
      sel   = $urandom_range(0, 9);
      rd    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      wmask = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
      case (sel)
        0: begin addr = BASE; wdata[0] = ($urandom_range(0, 3) == 0); end
        1: begin addr = BASE | 32'h4; wdata = 32'($urandom_range(0, 5)); end
        2: addr = BASE | 32'h8;
        3: addr = BASE | 32'hC;
        4, 5: addr = WIN | (32'($urandom_range(0, 15)) << 2);
        6: addr = ($urandom_range(0, 1) != 0) ? (WIN | 32'hFFC) : WIN;
        7: addr = 32'h1005_0000 | (32'($urandom_range(0, 16383)) << 2);
        8: addr = WIN | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        default: addr = unmapped[$urandom_range(0, 3)];
      endcase
      if ($urandom_range(0, 7) == 0) pulse_done();
      do_txn(rd, addr, wdata, wmask, ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    // Make mode and irq non-zero, then reset while a window read is in RD_WAIT.
    do_txn(0, BASE | 32'hC, 32'h6, 4'hF);
    do_txn(0, BASE, 32'h2, 4'hF);
    pulse_done();
    do_txn(1, BASE | 32'h8, 32'h0, 4'h0);
    wait_idle();
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = WIN | 32'h8;
    @(posedge clk); #1;
    icb_cmd_read = 1'b0; icb_cmd_wdata = 32'hFFFF_FFFF; icb_cmd_wmask = 4'hF;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_rdwait");
    @(posedge clk); #1;
    icb_cmd_valid = 1'b0;
    sb.delete();
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_txn(1, BASE | 32'h4, 32'h0, 4'h0);
    do_txn(1, BASE | 32'h8, 32'h0, 4'h0);
    do_txn(1, BASE | 32'hC, 32'h0, 4'h0);
    do_txn(1, WIN | 32'h8, 32'h0, 4'h0);

    wait_idle();
    check("sb_drained", 32'(sb.size()), 32'd0);
    finish_run();
  end

endmodule
